// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry FIFO output stage after the ALU compare units,
// with a saturating zero-flag counter and a sticky flag/result check.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_result/in_flag
// upstream; out_valid/out_ready/out_result/out_flag downstream;
// zero_count, flag_err status; clear_count clears both status outputs.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_flag,
  output logic [CNT_W-1:0] zero_count,
  output logic             flag_err,
  input  logic             clear_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  occ_t state, state_nx;

  logic [WIDTH-1:0] mem_r [2];
  logic             mem_f [2];
  logic             hd, tl;
  logic             push, pop, mism;

  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready  = rst_n & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign mism      = in_flag != (in_result == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL: if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    out_result = '0;
    out_flag   = 1'b0;
    if (state != EMPTY) begin
      out_result = mem_r[hd];
      out_flag   = mem_f[hd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      hd    <= 1'b0;
      tl    <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) tl <= ~tl;
      if (pop)  hd <= ~hd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[tl] <= in_result;
      mem_f[tl] <= in_flag;
    end
  end

  // Clear wins over the running value, but the push in the
  // same cycle still counts against the cleared state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_count <= '0;
      flag_err   <= 1'b0;
    end else if (clear_count) begin
      zero_count <= (push && in_flag) ? CNT_ONE : '0;
      flag_err   <= push & mism;
    end else if (push) begin
      if (in_flag && !(&zero_count))
        zero_count <= zero_count + CNT_ONE;
      if (mism)
        flag_err <= 1'b1;
    end
  end

endmodule
